// File: rtl/onehot_chk_pkg.sv
// Shared types and helpers for one-hot state checkers.
//   chk_state_t      : tracking FSM state (IDLE / TRACK / FAULT)
//   onehot_next_idx  : rotate-left successor index, (idx+1) mod n
package onehot_chk_pkg;

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} chk_state_t;

  function automatic int unsigned onehot_next_idx(input int unsigned idx,
                                                  input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot to binary index encoder.
//   state       : N-bit vector under test
//   idx_c       : index of the set bit when one-hot, else 0
//   is_onehot_c : exactly one bit of state is set
module onehot_decode #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         state,
  output logic [$clog2(N)-1:0] idx_c,
  output logic                 is_onehot_c
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CW    = $clog2(N + 1);

  logic [CW-1:0]    ones;
  logic [IDX_W-1:0] enc;

  // Popcount and last-set-bit encode in one pass.
  always_comb begin
    ones = '0;
    enc  = '0;
    for (int i = 0; i < N; i++) begin
      if (state[i]) begin
        ones = ones + CW'(1);
        enc  = IDX_W'(i);
      end
    end
    is_onehot_c = (ones == CW'(1));
    idx_c       = is_onehot_c ? enc : '0;
  end

endmodule

// File: rtl/onehot_state_checker.sv
// Run-time checker/decoder for a one-hot FSM state vector.
//   clk, rst   : clock, synchronous active-high reset
//   state_in   : one-hot vector under check
//   check_en   : sample and check this cycle
//   clr        : clear sticky flag, counter and tracking FSM
//   idx        : binary index of the last sample (0 if not one-hot)
//   idx_valid  : last sample was exactly one-hot
//   not_onehot : pulse, last sample had zero or several bits set
//   bad_trans  : pulse, last sample one-hot but not a legal successor
//   err_sticky : any violation since last clr/rst
//   err_cnt    : saturating count of violating samples
module onehot_state_checker
  import onehot_chk_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         state_in,
  input  logic                 check_en,
  input  logic                 clr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 idx_valid,
  output logic                 not_onehot,
  output logic                 bad_trans,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned IDX_W = $clog2(N);

  chk_state_t       state_q, state_d;
  logic [IDX_W-1:0] ref_idx_q, ref_idx_d;
  logic [IDX_W-1:0] dec_idx_c, succ_idx_c;
  logic             dec_onehot_c, legal_succ_c, viol_c;
  logic [IDX_W-1:0] idx_d;
  logic             idx_valid_d, not_onehot_d, bad_trans_d, err_sticky_d;
  logic [CNT_W-1:0] err_cnt_d;

  onehot_decode #(.N(N)) u_decode (
    .state       (state_in),
    .idx_c       (dec_idx_c),
    .is_onehot_c (dec_onehot_c)
  );

  // State, stored reference index and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ref_idx_q  <= '0;
      idx        <= '0;
      idx_valid  <= 1'b0;
      not_onehot <= 1'b0;
      bad_trans  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      ref_idx_q  <= ref_idx_d;
      idx        <= idx_d;
      idx_valid  <= idx_valid_d;
      not_onehot <= not_onehot_d;
      bad_trans  <= bad_trans_d;
      err_sticky <= err_sticky_d;
      err_cnt    <= err_cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    ref_idx_d    = ref_idx_q;
    idx_d        = idx;
    idx_valid_d  = 1'b0;
    not_onehot_d = 1'b0;
    bad_trans_d  = 1'b0;
    err_sticky_d = err_sticky;
    err_cnt_d    = err_cnt;

    succ_idx_c   = IDX_W'(onehot_next_idx(32'(ref_idx_q), N));
    legal_succ_c = (dec_idx_c == ref_idx_q) || (dec_idx_c == succ_idx_c);

    // Transition check only applies with a trusted reference (TRACK).
    if (check_en) begin
      idx_d        = dec_idx_c;
      idx_valid_d  = dec_onehot_c;
      not_onehot_d = !dec_onehot_c;
      bad_trans_d  = dec_onehot_c && (state_q == TRACK) && !legal_succ_c;
    end
    viol_c = not_onehot_d | bad_trans_d;

    if (!check_en) begin
      state_d = IDLE;
    end else if (viol_c) begin
      state_d = FAULT;
    end else begin
      state_d   = TRACK;
      ref_idx_d = dec_idx_c;
    end

    // clr overrides status and tracking, but the pulses above still report.
    if (clr) begin
      state_d      = IDLE;
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end else if (viol_c) begin
      err_sticky_d = 1'b1;
      if (err_cnt != '1) err_cnt_d = err_cnt + CNT_W'(1);
    end
  end

endmodule
